accum_stage: RTL and testbench

//  Downstream consumer of the N-bit load/mux register stage. Accepts its registered output q
//  as a stream of samples and accumulates a burst of CNT samples into a widened sum.

---
 rtl/accum_pkg.sv | 27 ++
 rtl/burst_counter.sv | 29 ++
 rtl/accum_stage.sv | 105 ++++++++++
 tb/tb_accum_stage.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared definitions for the accumulate stage: FSM encodings and width helpers.
// The upstream register stage sizes itself with the same clog2.
package accum_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int cnt_width(input int cnt);
      return (clog2(cnt) < 1) ? 1 : clog2(cnt);
   endfunction

   // At least one guard bit so CNT=1 still yields a width above N.
   function automatic int sum_width(input int n, input int cnt);
      return n + cnt_width(cnt);
   endfunction

endpackage

// File: rtl/burst_counter.sv
// Counts accepted samples within a burst; last flags the final sample slot.
module burst_counter #(
   parameter int CW  = 2,
   parameter int CNT = 4
) (
   input  logic clk,
   input  logic clr_n,
   input  logic clear,
   input  logic inc,
   output logic last
);

   localparam logic [CW-1:0] LAST_IDX = CW'(CNT - 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_count <= '0;
      end else if (clear || (inc && last)) begin
         r_count <= '0;
      end else if (inc) begin
         r_count <= r_count + CW'(1);
      end
   end

   assign last = (r_count == LAST_IDX);

endmodule

// File: rtl/accum_stage.sv
// Accumulates bursts of CNT samples from the upstream register stage and
// presents the widened total through a valid/ready handshake.
module accum_stage
   import accum_pkg::*;
#(
   parameter  int N   = 4,
   parameter  int CNT = 4,
   localparam int CW  = cnt_width(CNT),
   localparam int SW  = sum_width(N, CNT)
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          start,
   input  logic          in_valid,
   input  logic [N-1:0]  q_in,
   output logic          in_ready,
   output logic          busy,
   output logic [SW-1:0] sum,
   output logic          out_valid,
   input  logic          out_ready
);

   state_t        r_state;
   state_t        w_next;
   logic [SW-1:0] r_acc;
   logic [SW-1:0] r_sum;
   logic          r_out_valid;

   logic          w_take;
   logic          w_hs;
   logic          w_clear;
   logic          w_last;
   logic [SW-1:0] w_acc_nxt;

   assign w_take    = in_valid && (r_state == ST_ACC);
   assign w_hs      = r_out_valid && out_ready;
   assign w_acc_nxt = r_acc + SW'(q_in);

   burst_counter #(
      .CW  (CW),
      .CNT (CNT)
   ) u_cnt (
      .clk   (clk),
      .clr_n (clr_n),
      .clear (w_clear),
      .inc   (w_take),
      .last  (w_last)
   );

   always_comb begin
      w_next  = r_state;
      w_clear = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next  = ST_ACC;
               w_clear = 1'b1;
            end
         end
         ST_ACC: begin
            if (w_take && w_last) w_next = ST_HOLD;
         end
         ST_HOLD: begin
            // A handshake with start held restarts without an idle gap.
            if (w_hs) begin
               if (start) begin
                  w_next  = ST_ACC;
                  w_clear = 1'b1;
               end else begin
                  w_next  = ST_IDLE;
               end
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_state     <= ST_IDLE;
         r_acc       <= '0;
         r_sum       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_take) begin
            if (w_last) begin
               r_sum       <= w_acc_nxt;
               r_out_valid <= 1'b1;
               r_acc       <= '0;
            end else begin
               r_acc <= w_acc_nxt;
            end
         end
         if (w_hs)    r_out_valid <= 1'b0;
         if (w_clear) r_acc       <= '0;
      end
   end

   assign in_ready  = (r_state == ST_ACC);
   assign busy      = (r_state == ST_ACC) || (r_state == ST_HOLD);
   assign sum       = r_sum;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_accum_stage.sv
// Directed bench for accum_stage (N=4, CNT=4): per-cycle vector table plus
// hand sequences for reset, held output, back-to-back restart and abort.
module tb_accum_stage;

   localparam int N   = 4;
   localparam int CNT = 4;
   localparam int SW  = 6;

   logic          clk = 1'b0;
   logic          clr_n;
   logic          start;
   logic          in_valid;
   logic [N-1:0]  q_in;
   logic          in_ready;
   logic          busy;
   logic [SW-1:0] sum;
   logic          out_valid;
   logic          out_ready;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   accum_stage #(.N(N), .CNT(CNT)) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .start     (start),
      .in_valid  (in_valid),
      .q_in      (q_in),
      .in_ready  (in_ready),
      .busy      (busy),
      .sum       (sum),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   typedef struct {
      logic          st;
      logic          iv;
      logic [N-1:0]  q;
      logic          ordy;
      logic          e_ir;
      logic          e_busy;
      logic          e_ov;
      logic [SW-1:0] e_sum;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic st, input logic iv, input logic [N-1:0] q,
                               input logic ordy, input logic e_ir, input logic e_busy,
                               input logic e_ov, input logic [SW-1:0] e_sum);
      vec_t v;
      v.st = st; v.iv = iv; v.q = q; v.ordy = ordy;
      v.e_ir = e_ir; v.e_busy = e_busy; v.e_ov = e_ov; v.e_sum = e_sum;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs, clock it, then sample just after the edge.
   task automatic cyc(input logic rn, input logic st, input logic iv,
                      input logic [N-1:0] q, input logic ordy);
      clr_n = rn; start = st; in_valid = iv; q_in = q; out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_flags(input string tag, input logic e_ir, input logic e_busy,
                            input logic e_ov);
      chk({tag, ".in_ready"},  int'(in_ready),  int'(e_ir));
      chk({tag, ".busy"},      int'(busy),      int'(e_busy));
      chk({tag, ".out_valid"}, int'(out_valid), int'(e_ov));
   endtask

   initial begin
      clr_n = 1'b0; start = 1'b0; in_valid = 1'b0; q_in = '0; out_ready = 1'b0;

      // Burst 3,5,7,1 -> 16
      tbl.push_back(mk(1, 0,  0, 0, 1, 1, 0,  0));
      tbl.push_back(mk(0, 1,  3, 0, 1, 1, 0,  0));
      tbl.push_back(mk(0, 1,  5, 0, 1, 1, 0,  0));
      tbl.push_back(mk(0, 1,  7, 0, 1, 1, 0,  0));
      tbl.push_back(mk(0, 1,  1, 0, 0, 1, 1, 16));
      tbl.push_back(mk(0, 0,  0, 1, 0, 0, 0,  0));
      // Max samples 15 x4 -> 60, no wrap
      tbl.push_back(mk(1, 0,  0, 0, 1, 1, 0,  0));
      tbl.push_back(mk(0, 1, 15, 0, 1, 1, 0,  0));
      tbl.push_back(mk(0, 1, 15, 0, 1, 1, 0,  0));
      tbl.push_back(mk(0, 1, 15, 0, 1, 1, 0,  0));
      tbl.push_back(mk(0, 1, 15, 0, 0, 1, 1, 60));
      tbl.push_back(mk(0, 0,  0, 1, 0, 0, 0,  0));
      // in_valid in IDLE ignored; gapped burst 1,2,3,4 with 15 on idle cycles -> 10
      tbl.push_back(mk(0, 1,  9, 0, 0, 0, 0,  0));
      tbl.push_back(mk(1, 0,  0, 0, 1, 1, 0,  0));
      tbl.push_back(mk(0, 1,  1, 0, 1, 1, 0,  0));
      tbl.push_back(mk(1, 0, 15, 0, 1, 1, 0,  0));
      tbl.push_back(mk(0, 1,  2, 0, 1, 1, 0,  0));
      tbl.push_back(mk(0, 0, 15, 0, 1, 1, 0,  0));
      tbl.push_back(mk(0, 1,  3, 0, 1, 1, 0,  0));
      tbl.push_back(mk(0, 0, 15, 0, 1, 1, 0,  0));
      tbl.push_back(mk(0, 1,  4, 0, 0, 1, 1, 10));
      tbl.push_back(mk(0, 1, 15, 0, 0, 1, 1, 10));
      tbl.push_back(mk(0, 0,  0, 1, 0, 0, 0,  0));

      // Reset with random inputs
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
         chk_flags("reset", 0, 0, 0);
         chk("reset.sum", int'(sum), 0);
      end

      for (int i = 0; i < tbl.size(); i++) begin
         cyc(1'b1, tbl[i].st, tbl[i].iv, tbl[i].q, tbl[i].ordy);
         chk_flags($sformatf("vec%0d", i), tbl[i].e_ir, tbl[i].e_busy, tbl[i].e_ov);
         if (tbl[i].e_ov) chk($sformatf("vec%0d.sum", i), int'(sum), int'(tbl[i].e_sum));
      end

      // Held output with stalled consumer, then back-to-back restart
      cyc(1, 1, 0, 0, 0);
      cyc(1, 0, 1, 2, 0);
      cyc(1, 0, 1, 3, 0);
      cyc(1, 0, 1, 4, 0);
      cyc(1, 0, 1, 5, 0);
      chk_flags("hold.enter", 0, 1, 1);
      chk("hold.enter.sum", int'(sum), 14);
      for (int i = 0; i < 5; i++) begin
         cyc(1, (i == 2), 1, 4'd9, 0);
         chk_flags($sformatf("hold.stall%0d", i), 0, 1, 1);
         chk($sformatf("hold.stall%0d.sum", i), int'(sum), 14);
      end
      cyc(1, 1, 0, 0, 1);
      chk_flags("b2b.restart", 1, 1, 0);
      for (int i = 0; i < 4; i++) cyc(1, 0, 1, 1, 0);
      chk_flags("b2b.done", 0, 1, 1);
      chk("b2b.sum", int'(sum), 4);
      cyc(1, 0, 0, 0, 1);
      chk_flags("b2b.release", 0, 0, 0);

      // Mid-burst reset discards partial data
      cyc(1, 1, 0, 0, 0);
      cyc(1, 0, 1, 9, 0);
      cyc(1, 0, 1, 9, 0);
      chk_flags("abort.pre", 1, 1, 0);
      cyc(0, 1, 1, 9, 1);
      chk_flags("abort.reset", 0, 0, 0);
      chk("abort.reset.sum", int'(sum), 0);
      cyc(1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 1, 2, 0);
         chk_flags($sformatf("abort.acc%0d", i), 1, 1, 0);
      end
      cyc(1, 0, 1, 2, 0);
      chk_flags("abort.done", 0, 1, 1);
      chk("abort.sum", int'(sum), 8);
      cyc(1, 0, 0, 0, 1);
      chk_flags("abort.release", 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
